// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- RV32I load/store unit in front of a single-ported, word-wide RAM.
//
// One request is held at a time. Loads read the addressed word and return
// the byte/halfword/word right-aligned and extended. Word stores write
// directly. Byte/halfword stores do a read-modify-write of the containing
// word. Illegal width codes and misaligned accesses go straight to the
// response with resp_err=1 and never touch the RAM.
//
// Optional feature: define LSU_BOUNDS_CHECK_EN to also reject addresses
// outside [START_ADDR, START_ADDR+MEM_SIZE-1]. Without it the RAM sees every
// aligned address.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_we, req_funct3       1=store/0=load, RV32I width code
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid / resp_ready  response handshake
//   resp_rdata, resp_err     extended load data (0 for stores/errors), error
//   mem_addr, mem_we, mem_wd word-aligned RAM address, write enable, data
//   mem_rd                   RAM read data, combinational from mem_addr
// ---------------------------------------------------------------------------
module lsu #(
  parameter logic [31:0] START_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_SIZE   = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;   // RAM word captured for read-modify-write
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Decide whether a request is rejected without any RAM access.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic e;
    e = 1'b0;
    case (f3)
      3'b000, 3'b100: e = 1'b0;
      3'b001, 3'b101: e = addr[0];
      3'b010:         e = (addr[1:0] != 2'b00);
      default:        e = 1'b1;
    endcase
    // Stores only exist as SB/SH/SW.
    if (we && (f3 > 3'b010)) begin
      e = 1'b1;
    end else begin
      e = e;
    end
`ifdef LSU_BOUNDS_CHECK_EN
    // Unsigned offset wraps for addresses below START_ADDR, so one compare
    // covers both ends of the window.
    if ((addr - START_ADDR) >= 32'(MEM_SIZE)) begin
      e = 1'b1;
    end else begin
      e = e;
    end
`endif
    return e;
  endfunction

  // Right-align the addressed lane and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'h00_0000, s[7:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/halfword of the old word; SW takes wdata whole.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000:  r[{off, 3'b000} +: 8] = wdata[7:0];
      3'b001:  r[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      word_q   <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic and state-decoded handshake / RAM controls.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          word_d   = 32'h0000_0000;
          rdata_d  = 32'h0000_0000;
          err_d    = req_error(req_we, req_funct3, req_addr);
          if (err_d) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = READ;
          end else if (req_funct3 == 3'b010) begin
            state_d = WRITE;
          end else begin
            state_d = READ;   // SB/SH need the old word first
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (!we_q) begin
          rdata_d = load_extend(mem_rd, addr_q[1:0], funct3_q);
          state_d = RESP;
        end else begin
          word_d  = mem_rd;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_we  = 1'b1;
        mem_wd  = store_merge(word_q, wdata_q, addr_q[1:0], funct3_q);
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h8000_0000, meaning the lowest byte address of the attached RAM.
REQ-002 SHALL have parameter MEM_SIZE, default 16384, meaning the RAM size in bytes (power of two, multiple of 4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, a core request is present.
REQ-006 SHALL have port req_ready, output, 1, the unit can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3, the RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have port req_addr, input, 32, the byte address.
REQ-010 SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, a response is held.
REQ-012 SHALL have port resp_ready, input, 1, the core accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32, load data, extended; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1, misaligned, illegal-funct3 or out-of-range access.
REQ-015 SHALL have port mem_addr, output, 32, the word-aligned address to the RAM port.
REQ-016 SHALL have port mem_we, output, 1, the RAM write enable (RAM writes on the clk edge).
REQ-017 SHALL have port mem_wd, output, 32, the RAM write data.
REQ-018 SHALL have port mem_rd, input, 32, the RAM read data, combinational from mem_addr.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL, in IDLE with req_valid, latch we/funct3/addr/wdata and transition by request type:
- error -> RESP
- load -> READ
- SW -> WRITE
- SB/SH -> READ
REQ-021 SHALL flag an error for any of:
- funct3 in {011,110,111}
- store funct3 > 010
- H/HU with addr[0]=1
- W with addr[1:0]!=0
REQ-022 SHALL, on error, never assert mem_we and never touch memory state.
REQ-023 SHALL drive mem_addr = {addr_q[31:2],2'b00} in every state; mem_we=1 only in WRITE; mem_wd=0 outside WRITE.
REQ-024 SHALL, in READ for a load, capture mem_rd shifted by addr_q[1:0] and sign- (B,H) or zero- (BU,HU) extended, then go to RESP.
REQ-025 SHALL, in READ for SB/SH, capture mem_rd, then go to WRITE.
REQ-026 SHALL, in WRITE, drive mem_wd as follows:
- SW: wdata_q
- SB/SH: the captured word with only the addressed byte/halfword replaced by the low bits of wdata_q
REQ-027 SHALL go from WRITE to RESP.
REQ-028 SHALL assert resp_valid in RESP and hold resp_rdata/resp_err stable until resp_ready=1, then return to IDLE on that edge.
REQ-029 SHALL meet these latencies, counting accept edge = cycle 0, at which resp_valid is asserted:
- error: cycle 1
- load: cycle 2
- SW: cycle 2
- SB/SH: cycle 3
REQ-030 SHALL not accept a new request in the cycle RESP is consumed; back-to-back throughput is one request per latency+1 cycles.

Reset
REQ-031 SHALL, on rst at any edge, enter IDLE with all latched registers cleared, so that after reset mem_addr=0, mem_we=0, mem_wd=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
REQ-032 SHALL, when rst is asserted in WRITE, let the RAM write on that same edge complete (mem_we is decoded from state); no further access follows, and the response is discarded.
REQ-033 SHALL ignore req_valid while rst=1.

Configuration
REQ-034 SHALL, with LSU_BOUNDS_CHECK_EN defined, also flag an error when addr is outside [START_ADDR, START_ADDR+MEM_SIZE-1].
REQ-035 SHALL, without LSU_BOUNDS_CHECK_EN, perform no range check and pass all aligned addresses through.

Verification
REQ-036 SHALL cover: RAM word 0x8000_0000 = 0x0500_006F; LW 0x8000_0000 -> resp_valid at cycle 2, rdata 0x0500_006F, err 0.
REQ-037 SHALL cover: same word; LB 0x8000_0003 -> rdata 0x0000_0005; LBU 0x8000_0000 -> 0x0000_006F; LH 0x8000_0002 -> 0x0000_0500.
REQ-038 SHALL cover: word = 0x1234_5678; SB 0x8000_0001 with wdata 0xFFFF_FFAB -> single mem_we pulse at cycle 2 with mem_wd 0x1234_AB78; resp at cycle 3.
REQ-039 SHALL cover: LW 0x8000_0002 -> resp_err=1 at cycle 1, rdata 0, mem_we never asserted.
REQ-040 SHALL cover: with LSU_BOUNDS_CHECK_EN, SW 0x8000_4000 -> err=1, no write; without the macro, mem_we pulse with mem_addr 0x8000_4000.
REQ-041 SHALL cover: resp_ready held 0 for 5 cycles -> resp held stable, req_ready=0; rst in READ -> IDLE next cycle, no write.
